// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC sequencer and its index counter.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Operand memory read latency and total issue-to-product latency.
  localparam int MAC_RD_LAT    = 1;
  localparam int MAC_ISSUE_LAT = 2;

  // Index field width for a dimension; never narrower than one bit.
  function automatic int idx_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mac_idx_counter.sv
// Nested (m, n, k) iteration counter: k innermost, then n, then m.
module mac_idx_counter
  import mac_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                advance,
  output logic [idx_w(M)-1:0] m,
  output logic [idx_w(N)-1:0] n,
  output logic [idx_w(K)-1:0] k,
  output logic                last
);

  localparam int MW = idx_w(M);
  localparam int NW = idx_w(N);
  localparam int KW = idx_w(K);
  localparam logic [MW-1:0] M_LAST = MW'(M - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  logic [MW-1:0] m_q, m_d;
  logic [NW-1:0] n_q, n_d;
  logic [KW-1:0] k_q, k_d;

  // Next index: clear wins, otherwise step k with carries into n and m.
  always_comb begin
    m_d = m_q;
    n_d = n_q;
    k_d = k_q;
    if (clear) begin
      m_d = '0;
      n_d = '0;
      k_d = '0;
    end else if (advance) begin
      if (k_q == K_LAST) begin
        k_d = '0;
        if (n_q == N_LAST) begin
          n_d = '0;
          m_d = (m_q == M_LAST) ? '0 : m_q + 1'b1;
        end else begin
          n_d = n_q + 1'b1;
        end
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  // Index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q <= '0;
      n_q <= '0;
      k_q <= '0;
    end else begin
      m_q <= m_d;
      n_q <= n_d;
      k_q <= k_d;
    end
  end

  assign m    = m_q;
  assign n    = n_q;
  assign k    = k_q;
  assign last = (m_q == M_LAST) && (n_q == N_LAST) && (k_q == K_LAST);

endmodule

// File: rtl/mac_sequencer.sv
// Matrix-multiply MAC sequencer: issues A/B reads over M x N x K, registers
// the operand product with aligned index tags, and checks accumulator completion.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int M                      = 4,
  parameter int K                      = 4,
  parameter int N                      = 4,
  parameter int DATA_WIDTH_INIT_MATRIX = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                seq_error,
  output logic                                rd_en,
  output logic [idx_w(M)-1:0]                 addr_a_row,
  output logic [idx_w(K)-1:0]                 addr_a_col,
  output logic [idx_w(K)-1:0]                 addr_b_row,
  output logic [idx_w(N)-1:0]                 addr_b_col,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_a,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_b,
  output logic [2*DATA_WIDTH_INIT_MATRIX-1:0] product_reg,
  output logic                                mult_done_reg,
  output logic [idx_w(M)-1:0]                 matrix_a_row_addr_counter_reg,
  output logic [idx_w(K)-1:0]                 matrix_a_col_addr_counter_reg,
  output logic [idx_w(K)-1:0]                 matrix_b_row_addr_counter_reg,
  output logic [idx_w(N)-1:0]                 matrix_b_col_addr_counter_reg,
  input  logic                                mac_done
);

  localparam int MW = idx_w(M);
  localparam int NW = idx_w(N);
  localparam int KW = idx_w(K);
  localparam int DW = DATA_WIDTH_INIT_MATRIX;
  localparam int PW = 2 * DATA_WIDTH_INIT_MATRIX;
  localparam logic [1:0]    DRAIN_LAST = 2'(MAC_ISSUE_LAT - 1);
  localparam logic [MW-1:0] M_LAST     = MW'(M - 1);
  localparam logic [NW-1:0] N_LAST     = NW'(N - 1);
  localparam logic [KW-1:0] K_LAST     = KW'(K - 1);

  // Full-width unsigned product; no truncation or saturation.
  function automatic logic [PW-1:0] umul_full(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  seq_state_t    state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_en_q, rd_en_d;
  logic [1:0]    drain_q, drain_d;
  logic          seq_error_q, seq_error_d;
  logic          accept;
  logic          cnt_last;
  logic [MW-1:0] m_idx;
  logic [NW-1:0] n_idx;
  logic [KW-1:0] k_idx;

  assign accept = (state_q == IDLE) && start;

  mac_idx_counter #(.M(M), .N(N), .K(K)) u_idx (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .advance (state_q == RUN),
    .m       (m_idx),
    .n       (n_idx),
    .k       (k_idx),
    .last    (cnt_last)
  );

  // Sequencer next state and registered control outputs.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_en_d = rd_en_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          rd_en_d = 1'b1;
        end
      end
      RUN: begin
        if (cnt_last) begin
          state_d = DRAIN;
          rd_en_d = 1'b0;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        rd_en_d = 1'b0;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      drain_q <= drain_d;
    end
  end

  // ---- stage p1: read in flight, capture issue tag and valid ----
  logic          vld_p1_q;
  logic [MW-1:0] m_p1_q;
  logic [KW-1:0] k_p1_q;
  logic [NW-1:0] n_p1_q;

  // Stage-1 valid; cleared by reset so in-flight reads are discarded.
  always_ff @(posedge clk) begin
    if (reset) vld_p1_q <= 1'b0;
    else       vld_p1_q <= rd_en_q;
  end

  // Stage-1 tag capture; only meaningful while vld_p1_q is set.
  always_ff @(posedge clk) begin
    m_p1_q <= m_idx;
    k_p1_q <= k_idx;
    n_p1_q <= n_idx;
  end

  // ---- stage p2: product and tags presented to the accumulator ----
  logic          vld_p2_q, vld_p2_d;
  logic [PW-1:0] product_p2_q, product_p2_d;
  logic [MW-1:0] m_p2_q, m_p2_d;
  logic [KW-1:0] k_p2_q, k_p2_d;
  logic [NW-1:0] n_p2_q, n_p2_d;

  // Tags are forced to zero on invalid cycles so b_row never reads K-1 idle.
  always_comb begin
    vld_p2_d     = vld_p1_q;
    product_p2_d = vld_p1_q ? umul_full(data_a, data_b) : product_p2_q;
    m_p2_d       = vld_p1_q ? m_p1_q : '0;
    k_p2_d       = vld_p1_q ? k_p1_q : '0;
    n_p2_d       = vld_p1_q ? n_p1_q : '0;
  end

  // Stage-2 output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2_q     <= 1'b0;
      product_p2_q <= '0;
      m_p2_q       <= '0;
      k_p2_q       <= '0;
      n_p2_q       <= '0;
    end else begin
      vld_p2_q     <= vld_p2_d;
      product_p2_q <= product_p2_d;
      m_p2_q       <= m_p2_d;
      k_p2_q       <= k_p2_d;
      n_p2_q       <= n_p2_d;
    end
  end

  // mac_done must coincide exactly with the final product on stage 2.
  logic final_p2;
  assign final_p2 = vld_p2_q && (m_p2_q == M_LAST) && (k_p2_q == K_LAST) && (n_p2_q == N_LAST);

  // Sticky error: cleared by an accepted start, set on any completion mismatch.
  always_comb begin
    seq_error_d = (accept ? 1'b0 : seq_error_q) | (final_p2 ^ mac_done);
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (reset) seq_error_q <= 1'b0;
    else       seq_error_q <= seq_error_d;
  end

  assign busy                          = busy_q;
  assign done                          = done_q;
  assign seq_error                     = seq_error_q;
  assign rd_en                         = rd_en_q;
  assign addr_a_row                    = m_idx;
  assign addr_a_col                    = k_idx;
  assign addr_b_row                    = k_idx;
  assign addr_b_col                    = n_idx;
  assign product_reg                   = product_p2_q;
  assign mult_done_reg                 = vld_p2_q;
  assign matrix_a_row_addr_counter_reg = m_p2_q;
  assign matrix_a_col_addr_counter_reg = k_p2_q;
  assign matrix_b_row_addr_counter_reg = k_p2_q;
  assign matrix_b_col_addr_counter_reg = n_p2_q;

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Control block that drives the matrix-multiply MAC datapath. On a `start` pulse it walks the full M×N×K iteration space and issues synchronous reads to the A and B operand memories. It registers the operand product and presents `product_reg`, `mult_done_reg` and index tags aligned to that product, which are the exact inputs `mac_stop_accum` consumes. It closes the job by checking the accumulator's `mac_done` and pulsing `done`.

## Interface
- `M`, 4, rows of A / C (≥2)
- `K`, 4, inner dimension (≥2; K=1 unsupported because idle tags would alias K-1)
- `N`, 4, columns of B / C (≥2)
- `DATA_WIDTH_INIT_MATRIX`, 32, operand width, unsigned
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  job request, sampled only in IDLE
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  one-cycle pulse at job end
- `seq_error`  out  1  sticky; cleared by reset or by an accepted `start`
- `rd_en`  out  1  read strobe to A and B memories
- `addr_a_row`  out  $clog2(M)  A row index (m)
- `addr_a_col`  out  $clog2(K)  A column index (k)
- `addr_b_row`  out  $clog2(K)  B row index (k)
- `addr_b_col`  out  $clog2(N)  B column index (n)
- `data_a`  in  DATA_WIDTH_INIT_MATRIX  A read data, valid 1 cycle after `rd_en`
- `data_b`  in  DATA_WIDTH_INIT_MATRIX  B read data, valid 1 cycle after `rd_en`
- `product_reg`  out  2·DATA_WIDTH_INIT_MATRIX  registered `data_a*data_b`
- `mult_done_reg`  out  1  `product_reg` and tags valid
- `matrix_a_row_addr_counter_reg`, `matrix_a_col_addr_counter_reg`, `matrix_b_row_addr_counter_reg`, `matrix_b_col_addr_counter_reg`  out  same widths as the matching addresses  index tags aligned with `product_reg`
- `mac_done`  in  1  accumulator completion flag, combinational from the tags

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN when `start`=1. The same edge loads counters (m,n,k)=(0,0,0), drives them onto the address outputs and sets `rd_en`=1. Clears `seq_error`.
- RUN: one issue per cycle.
  - Loop order: k innermost, then n, then m.
  - k wraps K-1→0 and increments n. n wraps N-1→0 and increments m.
  - `addr_a_col` and `addr_b_row` both equal k.
  - On the edge after issuing (M-1,N-1,K-1), go to DRAIN with `rd_en`=0.
- DRAIN: exactly 2 cycles, enough for the last product to emit. Then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE. `start` in DONE is ignored.
- `start` in RUN, DRAIN or DONE has no effect.
- Pipeline, with `rd_en` at cycle t:
  - Stage 1 at t+1: capture the tag and a valid bit.
  - Stage 2 at t+2: `product_reg`, tags and `mult_done_reg`=1.
- Any cycle with stage-2 valid=0:
  - `mult_done_reg`=0 and all four tags=0, so the accumulator never sees b_row==K-1 spuriously.
  - `product_reg` holds its last value.
- Arithmetic: full-width unsigned product. No truncation and no saturation.
- Error check: on the cycle stage 2 carries tag (M-1,K-1,K-1,N-1), `mac_done` must be 1. Otherwise set `seq_error`. `mac_done`=1 with any other stage-2 content, or with valid=0, also sets `seq_error`.
- Reset (any state, including mid-RUN) returns to IDLE next edge and flushes the pipeline. In-flight products are discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `seq_error`=0, `rd_en`=0, all addresses and tags 0, `product_reg`=0, `mult_done_reg`=0, state IDLE.
- Let start be accepted at edge E0.
  - Issues occur in cycles 1…MNK.
  - `mult_done_reg` is high in cycles 3…MNK+2, continuously with no bubbles.
  - `done` is high in cycle MNK+3.
  - `busy` is high in cycles 1…MNK+2.
- For 4×4×4: 64 issues, last product in cycle 66, `done` in cycle 67.
- All outputs are registered. `mac_done` is sampled the same cycle as the final product.
- Minimum gap between `done` and the next accepted `start` edge is 1 cycle, because IDLE is entered after DONE.

## Structure
- Shared package `mac_pkg`:
  - State enum `seq_state_t` (IDLE, RUN, DRAIN, DONE).
  - Constant `MAC_RD_LAT`=1 (memory read latency).
  - Constant `MAC_ISSUE_LAT`=2 (issue-to-product).
  - Width helper functions for the index fields.
- Sub-module `mac_idx_counter`: the nested k/n/m wrap counter.
  - Ports: `clk`, `reset`, `clear`, `advance`, `m`, `n`, `k`, `last`.
  - The FSM, operand pipeline and error checker stay in `mac_sequencer`.

## Test plan
- M=N=K=4 with A=identity and B[k][n]=k·4+n: 64 `rd_en` cycles in (m,n,k) order; `mult_done_reg` high in cycles 3–66; `done` in cycle 67; `seq_error`=0; with the accumulator attached, C equals B.
- Operands 0xFFFFFFFF×0xFFFFFFFF: `product_reg`=0xFFFFFFFE00000001 two cycles after issue.
- `start` held high throughout a job: exactly one job runs; one `done`; IDLE is re-entered, and a new job starts in the cycle after DONE if `start` is still high.
- `reset` asserted in cycle 20 of RUN: next cycle `busy`=0, `rd_en`=0, `mult_done_reg`=0, tags 0; a following `start` runs cleanly from (0,0,0).
- `mac_done` stub tied 0: `seq_error` rises in cycle MNK+3 and stays high through IDLE until the next accepted `start`.
- Idle with `mac_done` pulsed in IDLE: `seq_error` sets; `matrix_b_row_addr_counter_reg` stays 0 throughout idle.
